fpu_ss_mem_responder: RTL and testbench

Core-side responder for the X-interface memory request/result channels driven by the FPU subsystem. Accepts coprocessor load/store requests, forwards them onto the core's OBI data port, and returns exactly one in-order memory result per accepted request. It tracks up to DEPTH outstanding transactions. Misaligned word accesses are answered locally as exceptions without any bus traffic.

---
 rtl/fpu_ss_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_fpu_ss_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_mem_responder.sv
// fpu_ss_mem_responder
//
// Core-side responder for the X-interface memory request/result channels.
// Coprocessor load/store requests are forwarded to the core's OBI data port,
// and exactly one in-order memory result is returned per accepted request.
// Up to DEPTH accepted requests may be outstanding. Misaligned word accesses
// never reach the bus; they are answered locally as exceptions.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   x_mem_valid_i/ready_o       request handshake (accept = valid & ready)
//   x_mem_req_*_i               request id, address, we, be, wdata, spec, last
//   x_mem_resp_*_o              same-cycle response: valid, exc, exccode
//   x_mem_result_*_o            in-order result: valid, id, rdata, err
//   data_req_o ... data_be_o    OBI request channel
//   data_gnt_i ... data_rdata_i OBI grant and response channel
module fpu_ss_mem_responder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ID_W  = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            x_mem_valid_i,
    output logic            x_mem_ready_o,
    input  logic [ID_W-1:0] x_mem_req_id_i,
    input  logic [31:0]     x_mem_req_addr_i,
    input  logic            x_mem_req_we_i,
    input  logic [3:0]      x_mem_req_be_i,
    input  logic [31:0]     x_mem_req_wdata_i,
    input  logic            x_mem_req_spec_i,
    input  logic            x_mem_req_last_i,
    output logic            x_mem_resp_valid_o,
    output logic            x_mem_resp_exc_o,
    output logic [5:0]      x_mem_resp_exccode_o,
    output logic            x_mem_result_valid_o,
    output logic [ID_W-1:0] x_mem_result_id_o,
    output logic [31:0]     x_mem_result_rdata_o,
    output logic            x_mem_result_err_o,
    output logic            data_req_o,
    output logic            data_we_o,
    output logic [31:0]     data_addr_o,
    output logic [31:0]     data_wdata_o,
    output logic [3:0]      data_be_o,
    input  logic            data_gnt_i,
    input  logic            data_rvalid_i,
    input  logic            data_err_i,
    input  logic [31:0]     data_rdata_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Outstanding-transaction FIFO: {id, we, exc} per entry
    logic [ID_W-1:0]  id_q [DEPTH];
    logic [DEPTH-1:0] we_q;
    logic [DEPTH-1:0] exc_q;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic misaligned_s, full_s, empty_s, exc_pend_s;
    logic bus_req_s, accept_s, pop_s;
    logic res_valid_s, res_err_s;
    logic [ID_W-1:0] res_id_s;
    logic [31:0] res_rdata_s;
    logic unused_s;

    // Pointer advance, wrapping modulo DEPTH (DEPTH need not be a power of 2)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign unused_s = x_mem_req_spec_i ^ x_mem_req_last_i;

    // Request acceptance, bus request and result selection
    always_comb begin
        misaligned_s = (x_mem_req_addr_i[1:0] != 2'b00) && (x_mem_req_be_i == 4'hF);
        full_s       = (cnt_q == DEPTH_C);
        empty_s      = (cnt_q == {CNT_W{1'b0}});
        exc_pend_s   = !empty_s && exc_q[rptr_q];

        bus_req_s = x_mem_valid_i && !misaligned_s && !full_s && !exc_pend_s;
        // A misaligned access waits until all bus traffic has drained so its
        // exception result lands in program order without a bus round trip.
        if (misaligned_s) begin
            accept_s = x_mem_valid_i && empty_s;
        end else begin
            accept_s = bus_req_s && data_gnt_i;
        end

        res_valid_s = 1'b0;
        res_err_s   = 1'b0;
        res_id_s    = {ID_W{1'b0}};
        res_rdata_s = 32'h0000_0000;
        if (exc_pend_s) begin
            // rvalid cannot legitimately arrive here: nothing is on the bus
            res_valid_s = 1'b1;
            res_err_s   = 1'b1;
            res_id_s    = id_q[rptr_q];
        end else if (data_rvalid_i && !empty_s) begin
            res_valid_s = 1'b1;
            res_err_s   = data_err_i;
            res_id_s    = id_q[rptr_q];
            if (we_q[rptr_q] || data_err_i) begin
                res_rdata_s = 32'h0000_0000;
            end else begin
                res_rdata_s = data_rdata_i;
            end
        end else begin
            // stray rvalid with nothing outstanding is dropped
            res_valid_s = 1'b0;
        end
        pop_s = res_valid_s;

        case ({accept_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (accept_s) begin
            wptr_d = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Count and pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= {CNT_W{1'b0}};
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // FIFO entry storage, written on accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                id_q[i] <= {ID_W{1'b0}};
            end
            we_q  <= {DEPTH{1'b0}};
            exc_q <= {DEPTH{1'b0}};
        end else if (accept_s) begin
            id_q[wptr_q]  <= x_mem_req_id_i;
            we_q[wptr_q]  <= x_mem_req_we_i;
            exc_q[wptr_q] <= misaligned_s;
        end
    end

    assign x_mem_ready_o        = accept_s;
    assign x_mem_resp_valid_o   = accept_s;
    assign x_mem_resp_exc_o     = accept_s && misaligned_s;
    assign x_mem_resp_exccode_o = (accept_s && misaligned_s) ?
                                  (x_mem_req_we_i ? 6'd6 : 6'd4) : 6'd0;

    assign x_mem_result_valid_o = res_valid_s;
    assign x_mem_result_id_o    = res_id_s;
    assign x_mem_result_rdata_o = res_rdata_s;
    assign x_mem_result_err_o   = res_err_s;

    // Bus fields follow the request but read as 0 while no request is offered
    assign data_req_o   = bus_req_s;
    assign data_we_o    = x_mem_valid_i && x_mem_req_we_i;
    assign data_addr_o  = x_mem_valid_i ? x_mem_req_addr_i  : 32'h0000_0000;
    assign data_wdata_o = x_mem_valid_i ? x_mem_req_wdata_i : 32'h0000_0000;
    assign data_be_o    = x_mem_valid_i ? x_mem_req_be_i    : 4'h0;

endmodule

// File: tb/tb_fpu_ss_mem_responder.sv
// Self-checking bench for fpu_ss_mem_responder (DEPTH = 2, ID_W = 4).
// Stimulus pushes expected responses/results into queues; a monitor on the
// falling edge pops and compares whenever the DUT strobes an output.
module tb_fpu_ss_mem_responder;

    typedef struct {
        logic       exc;
        logic [5:0] code;
    } resp_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] rdata;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_mem_valid, x_mem_ready;
    logic [3:0]  req_id;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_spec, req_last;
    logic        resp_valid, resp_exc;
    logic [5:0]  resp_exccode;
    logic        result_valid;
    logic [3:0]  result_id;
    logic [31:0] result_rdata;
    logic        result_err;
    logic        data_req, data_we;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_be;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    resp_t resp_q[$];
    res_t  res_q[$];

    fpu_ss_mem_responder #(.DEPTH(2), .ID_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .x_mem_valid_i(x_mem_valid), .x_mem_ready_o(x_mem_ready),
        .x_mem_req_id_i(req_id), .x_mem_req_addr_i(req_addr),
        .x_mem_req_we_i(req_we), .x_mem_req_be_i(req_be),
        .x_mem_req_wdata_i(req_wdata), .x_mem_req_spec_i(req_spec),
        .x_mem_req_last_i(req_last),
        .x_mem_resp_valid_o(resp_valid), .x_mem_resp_exc_o(resp_exc),
        .x_mem_resp_exccode_o(resp_exccode),
        .x_mem_result_valid_o(result_valid), .x_mem_result_id_o(result_id),
        .x_mem_result_rdata_o(result_rdata), .x_mem_result_err_o(result_err),
        .data_req_o(data_req), .data_we_o(data_we), .data_addr_o(data_addr),
        .data_wdata_o(data_wdata), .data_be_o(data_be),
        .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_err_i(data_err), .data_rdata_i(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    check("resp_exc_code", {57'd0, resp_exc, resp_exccode}, {57'd0, e.exc, e.code});
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    check("result_unexpected", 64'(result_valid), 64'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("result_id_rdata_err", {27'd0, result_id, result_rdata, result_err},
                          {27'd0, r.id, r.rdata, r.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        x_mem_valid = 1'b0; req_id = 4'd0; req_addr = 32'd0; req_we = 1'b0;
        req_be = 4'h0; req_wdata = 32'd0; req_spec = 1'b0; req_last = 1'b0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'd0;
    endtask

    task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata);
        x_mem_valid = 1'b1; req_id = id; req_addr = addr; req_we = we;
        req_be = 4'hF; req_wdata = wdata; req_last = 1'b1; data_gnt = 1'b1;
    endtask

    task automatic bus(input logic rv, input logic err, input logic [31:0] rdata);
        data_rvalid = rv; data_err = err; data_rdata = rdata;
    endtask

    task automatic exp_acc(input logic [3:0] id, input logic [31:0] rdata, input logic err);
        resp_q.push_back('{exc: 1'b0, code: 6'd0});
        res_q.push_back('{id: id, rdata: rdata, err: err});
    endtask

    task automatic exp_exc(input logic [3:0] id, input logic we);
        resp_q.push_back('{exc: 1'b1, code: (we ? 6'd6 : 6'd4)});
        res_q.push_back('{id: id, rdata: 32'd0, err: 1'b1});
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(x_mem_ready), 64'd0);
        check("reset_data_req", 64'(data_req), 64'd0);
        check("reset_result_valid", 64'(result_valid), 64'd0);
        rst_n = 1'b1;

        // single load
        step(); req(4'd3, 32'h100, 1'b0, 32'd0); exp_acc(4'd3, 32'hDEADBEEF, 1'b0);
        #1;
        check("load_ready", 64'(x_mem_ready), 64'd1);
        check("load_data_req", 64'(data_req), 64'd1);
        check("load_addr_we", {31'd0, data_we, data_addr}, {31'd0, 1'b0, 32'h100});
        step(); idle();
        step();
        step(); bus(1'b1, 1'b0, 32'hDEADBEEF);
        step(); idle();

        // store: rdata from the bus must be masked
        step(); req(4'd4, 32'h104, 1'b1, 32'h12345678); exp_acc(4'd4, 32'd0, 1'b0);
        #1;
        check("store_we_wdata", {31'd0, data_we, data_wdata}, {31'd0, 1'b1, 32'h12345678});
        step(); idle();
        step(); bus(1'b1, 1'b0, 32'hFFFFFFFF);
        step(); idle();

        // back-to-back loads up to full
        step(); req(4'd1, 32'h200, 1'b0, 32'd0); exp_acc(4'd1, 32'h000000A1, 1'b0);
        step(); req(4'd2, 32'h204, 1'b0, 32'd0); exp_acc(4'd2, 32'h000000A2, 1'b0);
        step(); req(4'd3, 32'h208, 1'b0, 32'd0);
        #1;
        check("full_ready", 64'(x_mem_ready), 64'd0);
        check("full_data_req", 64'(data_req), 64'd0);
        step(); bus(1'b1, 1'b0, 32'h000000A1);
        #1;
        check("full_pop_ready", 64'(x_mem_ready), 64'd0);
        step(); bus(1'b0, 1'b0, 32'd0); exp_acc(4'd3, 32'h000000A3, 1'b0);
        #1;
        check("refill_ready", 64'(x_mem_ready), 64'd1);
        step(); idle(); bus(1'b1, 1'b0, 32'h000000A2);
        step(); bus(1'b1, 1'b0, 32'h000000A3);
        step(); idle();

        // misaligned load stalls behind an outstanding load
        step(); req(4'd6, 32'h300, 1'b0, 32'd0); exp_acc(4'd6, 32'h00000066, 1'b0);
        step(); idle(); req(4'd5, 32'h102, 1'b0, 32'd0);
        #1;
        check("mis_stall_ready", 64'(x_mem_ready), 64'd0);
        check("mis_stall_req", 64'(data_req), 64'd0);
        step(); bus(1'b1, 1'b0, 32'h00000066);
        #1;
        check("mis_stall2_ready", 64'(x_mem_ready), 64'd0);
        step(); bus(1'b0, 1'b0, 32'd0); exp_exc(4'd5, 1'b0);
        #1;
        check("mis_accept_ready", 64'(x_mem_ready), 64'd1);
        check("mis_no_bus_req", 64'(data_req), 64'd0);
        // misaligned store blocked while the exception result is pending
        step(); idle(); req(4'd9, 32'h001, 1'b1, 32'd0);
        #1;
        check("exc_pend_ready", 64'(x_mem_ready), 64'd0);
        check("exc_result_now", {59'd0, result_valid, result_id}, {59'd0, 1'b1, 4'd5});
        step(); exp_exc(4'd9, 1'b1);
        #1;
        check("mis_store_ready", 64'(x_mem_ready), 64'd1);
        step(); idle();
        step();

        // full with rvalid, then simultaneous push and pop
        step(); req(4'd10, 32'h400, 1'b0, 32'd0); exp_acc(4'd10, 32'h000000B0, 1'b0);
        step(); req(4'd11, 32'h404, 1'b0, 32'd0); exp_acc(4'd11, 32'h000000B1, 1'b0);
        step(); req(4'd12, 32'h408, 1'b0, 32'd0); bus(1'b1, 1'b0, 32'h000000B0);
        #1;
        check("full_rvalid_ready", 64'(x_mem_ready), 64'd0);
        step(); bus(1'b0, 1'b0, 32'd0); exp_acc(4'd12, 32'h000000B2, 1'b0);
        step(); req(4'd13, 32'h40C, 1'b0, 32'd0); bus(1'b1, 1'b0, 32'h000000B1);
        #1;
        check("full2_ready", 64'(x_mem_ready), 64'd0);
        step(); bus(1'b1, 1'b0, 32'h000000B2); exp_acc(4'd13, 32'h000000B3, 1'b0);
        #1;
        check("pushpop_ready", 64'(x_mem_ready), 64'd1);
        step(); req(4'd14, 32'h410, 1'b0, 32'd0); bus(1'b0, 1'b0, 32'd0);
        exp_acc(4'd14, 32'h000000B4, 1'b0);
        #1;
        check("after_pushpop_ready", 64'(x_mem_ready), 64'd1);
        step(); req(4'd15, 32'h414, 1'b0, 32'd0);
        #1;
        check("full3_ready", 64'(x_mem_ready), 64'd0);
        step(); idle(); bus(1'b1, 1'b0, 32'h000000B3);
        step(); bus(1'b1, 1'b0, 32'h000000B4);
        step(); idle();

        // bus error, then a stray rvalid with nothing outstanding
        step(); req(4'd7, 32'h500, 1'b0, 32'd0); exp_acc(4'd7, 32'd0, 1'b1);
        step(); idle(); bus(1'b1, 1'b1, 32'h00000055);
        step(); idle(); bus(1'b1, 1'b0, 32'h00000077);
        #1;
        check("spurious_no_result", 64'(result_valid), 64'd0);
        step(); idle();

        // reset mid-transaction flushes the outstanding load
        step(); req(4'd8, 32'h600, 1'b0, 32'd0); exp_acc(4'd8, 32'h00000088, 1'b0);
        step(); idle(); rst_n = 1'b0;
        #1;
        res_q.delete();
        step(); rst_n = 1'b1;
        step(); bus(1'b1, 1'b0, 32'h00000088);
        #1;
        check("flushed_no_result", 64'(result_valid), 64'd0);
        step(); idle();
        step();

        check("resp_q_drained", 64'(resp_q.size()), 64'd0);
        check("res_q_drained", 64'(res_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
